burst_sequencer: RTL and testbench
==================================

Name: burst_sequencer

Overview:
- Controller that sequences the bitstreamer through a programmed list of data-word/phase-delay pairs, one burst per entry, repeated a programmable number of times.
- Sits between the system (HPS/Qsys exports, KEY trigger) and the bitstreamer. It drives the bitstreamer's datain, phase_delay and start, and watches its sysrun.
- Runs on ant_clk, the same clock as the bitstreamer, so sysrun needs no synchronizer.

Parameters:
- DATALEN, 32, width of the bitstream data word.
- CNTLEN, 8, width of the phase_delay field.
- NWORDS, 4, depth of the word table (power of two, at least 2). AW = clog2(NWORDS).
- GAPLEN, 16, width of the inter-burst gap counter.
- TOLEN, 16, width of the sysrun-assert timeout counter.

Ports:
- clk  in  1  sequencer clock (ant_clk).
- rst  in  1  reset; asynchronous, active-low.
- trig  in  1  sequence trigger; rising edge detected internally.
- abort  in  1  synchronous abort; level sensitive.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table write address.
- cfg_data  in  DATALEN  table data word.
- cfg_phase  in  CNTLEN  table phase delay.
- num_words  in  AW+1  number of table entries per pass (1..NWORDS).
- repeat_cnt  in  8  number of passes (0 is treated as 1).
- gap_cycles  in  GAPLEN  idle clocks after sysrun falls, before the next burst.
- timeout_cycles  in  TOLEN  maximum clocks from start to sysrun high (0 disables the timeout).
- sysrun  in  1  bitstreamer running flag.
- datain  out  DATALEN  word to the bitstreamer.
- phase_delay  out  CNTLEN  phase delay to the bitstreamer.
- start  out  1  one-cycle start pulse to the bitstreamer.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a sequence completes normally.
- err  out  1  sticky timeout flag.
- cur_idx  out  AW  table index of the current burst.

Behaviour:
- Reset values: all outputs 0, all table entries 0, trig edge register 0, FSM in IDLE.
- Table writes:
  - cfg_we writes {cfg_data, cfg_phase} at cfg_addr on the clock edge, in any state.
  - A write takes effect at the next LOAD that reads that entry.
- Configuration latching: num_words, repeat_cnt, gap_cycles and timeout_cycles are captured on trigger acceptance and held for the whole sequence.
- IDLE:
  - A trig rising edge (trig=1 now, 0 on the previous clock) is accepted only if 1 <= num_words <= NWORDS. Otherwise it is ignored and no flags change.
  - On accept: idx=0, pass=0, err cleared, go to LOAD.
- LOAD:
  - datain and phase_delay are registered from table[idx]; cur_idx=idx.
  - Go to START.
  - datain and phase_delay hold their value until the next LOAD, including after the sequence ends.
- START:
  - start=1 for exactly this cycle; timeout counter cleared.
  - Go to WAIT_RUN.
  - Latency: if trig is first sampled high at edge N, start is high during the cycle after edge N+2.
- WAIT_RUN:
  - sysrun=1: go to WAIT_END.
  - Else, if timeout_cycles != 0 and the counter equals timeout_cycles: set err=1, go to IDLE. The sequence is abandoned and done is not pulsed.
  - Else increment the counter, saturating at its maximum.
- WAIT_END:
  - Stay while sysrun=1. There is no timeout in this state.
  - sysrun=0: load the gap counter with gap_cycles, go to GAP.
- GAP:
  - Decrement until the counter is 0, then decide:
    - idx+1 < num_words: idx++, go to LOAD.
    - Else, pass+1 < max(repeat_cnt,1): pass++, idx=0, go to LOAD.
    - Else: go to DONE.
  - gap_cycles=0 gives exactly one GAP cycle.
- DONE: done=1 for one cycle, then go to IDLE.
- abort:
  - Wins over every transition. From any non-IDLE state, the next state is IDLE.
  - start is forced to 0 in that cycle; done is not pulsed; err is unchanged.
  - In IDLE, an abort=1 cycle also blocks trigger acceptance in that cycle.
- trig edges while busy are ignored and not queued.
- idx and pass wrap only through the explicit compares above; idx never exceeds num_words-1.
- Asynchronous reset mid-sequence: the FSM goes to IDLE, all outputs clear immediately, table contents clear.

Test Plan:
- Single burst:
  - Stimulus: table[0]={32'hA5A5_0F0F, 8'd3}, num_words=1, repeat_cnt=1, gap=4. Pulse trig; model sysrun high 2 clocks after start, for 10 clocks.
  - Required: start is a single pulse 2 clocks after the trig sample; datain=A5A50F0F and phase_delay=3 before start; done pulses 5 clocks after sysrun falls; busy low afterwards.
- Multi-word, multi-pass:
  - Stimulus: num_words=3, repeat_cnt=2.
  - Required: 6 start pulses; cur_idx sequence 0,1,2,0,1,2; each datain matches its table entry; exactly one done.
- Timeout:
  - Stimulus: timeout_cycles=5, sysrun held 0.
  - Required: err=1 6 clocks after start; FSM in IDLE; no done.
  - Follow-up: the next accepted trig clears err.
- Abort:
  - Stimulus: assert abort during WAIT_END of burst 2 of 4.
  - Required: IDLE next clock; no further start; no done; err unchanged.
- Invalid configuration and boundaries:
  - num_words=0 or NWORDS+1 with trig: no response, busy stays 0.
  - repeat_cnt=0 behaves as 1.
  - gap_cycles=0: next start 3 clocks after sysrun falls.
- Runtime robustness:
  - Table write to entry 1 during burst 0: burst 1 uses the new data.
  - Async rst mid-GAP: all outputs 0 immediately.

Source files
------------

// File: rtl/burst_sequencer.sv
// Burst sequencer: walks a small table of {data word, phase delay} entries and
// issues one bitstreamer burst per entry, repeated for a programmed number of
// passes. Shares ant_clk with the bitstreamer, so sysrun is used directly.
module burst_sequencer #(
    parameter int DATALEN = 32,
    parameter int CNTLEN  = 8,
    parameter int NWORDS  = 4,
    parameter int GAPLEN  = 16,
    parameter int TOLEN   = 16,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic               abort,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DATALEN-1:0] cfg_data,
    input  logic [CNTLEN-1:0]  cfg_phase,
    input  logic [AW:0]        num_words,
    input  logic [7:0]         repeat_cnt,
    input  logic [GAPLEN-1:0]  gap_cycles,
    input  logic [TOLEN-1:0]   timeout_cycles,
    input  logic               sysrun,
    output logic [DATALEN-1:0] datain,
    output logic [CNTLEN-1:0]  phase_delay,
    output logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      cur_idx
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitRun,
        StWaitEnd,
        StGap,
        StDone
    } state_e;

    localparam logic [AW:0] NW_MAX = NWORDS[AW:0];

    state_e              state_q, state_d;
    logic                trig_q, trig_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [7:0]          pass_q, pass_d;
    logic [AW:0]         nw_q, nw_d;
    logic [7:0]          rep_q, rep_d;
    logic [GAPLEN-1:0]   gap_lat_q, gap_lat_d;
    logic [TOLEN-1:0]    to_lat_q, to_lat_d;
    logic [GAPLEN-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TOLEN-1:0]    to_cnt_q, to_cnt_d;
    logic [DATALEN-1:0]  datain_q, datain_d;
    logic [CNTLEN-1:0]   phase_q, phase_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [AW-1:0]       cur_idx_q, cur_idx_d;

    logic [DATALEN-1:0]  data_mem_q [NWORDS];
    logic [DATALEN-1:0]  data_mem_d [NWORDS];
    logic [CNTLEN-1:0]   phase_mem_q [NWORDS];
    logic [CNTLEN-1:0]   phase_mem_d [NWORDS];

    logic                trig_rise;
    logic                nw_valid;
    logic [7:0]          rep_eff;
    logic [AW:0]         idx_next;
    logic [8:0]          pass_next;

    assign trig_rise = trig && !trig_q;
    assign nw_valid  = (num_words != '0) && (num_words <= NW_MAX);
    // A repeat count of zero still runs one pass.
    assign rep_eff   = (rep_q == 8'd0) ? 8'd1 : rep_q;
    assign idx_next  = {1'b0, idx_q} + 1'b1;
    assign pass_next = {1'b0, pass_q} + 9'd1;

    // Table write port, usable in any state.
    always_comb begin
        data_mem_d  = data_mem_q;
        phase_mem_d = phase_mem_q;
        if (cfg_we) begin
            data_mem_d[cfg_addr]  = cfg_data;
            phase_mem_d[cfg_addr] = cfg_phase;
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        trig_d    = trig;
        idx_d     = idx_q;
        pass_d    = pass_q;
        nw_d      = nw_q;
        rep_d     = rep_q;
        gap_lat_d = gap_lat_q;
        to_lat_d  = to_lat_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        datain_d  = datain_q;
        phase_d   = phase_q;
        err_d     = err_q;
        cur_idx_d = cur_idx_q;

        unique case (state_q)
            StIdle: begin
                if (!abort && trig_rise && nw_valid) begin
                    idx_d     = '0;
                    pass_d    = '0;
                    err_d     = 1'b0;
                    nw_d      = num_words;
                    rep_d     = repeat_cnt;
                    gap_lat_d = gap_cycles;
                    to_lat_d  = timeout_cycles;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                datain_d  = data_mem_q[idx_q];
                phase_d   = phase_mem_q[idx_q];
                cur_idx_d = idx_q;
                state_d   = StStart;
            end
            StStart: begin
                to_cnt_d = '0;
                state_d  = StWaitRun;
            end
            StWaitRun: begin
                if (sysrun) begin
                    state_d = StWaitEnd;
                end else if ((to_lat_q != '0) && (to_cnt_q == to_lat_q)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StWaitEnd: begin
                if (!sysrun) begin
                    gap_cnt_d = gap_lat_q;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else if (idx_next < nw_q) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StLoad;
                end else if (pass_next < {1'b0, rep_eff}) begin
                    pass_d  = pass_q + 8'd1;
                    idx_d   = '0;
                    state_d = StLoad;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition and leaves err and the burst outputs alone.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            err_d     = err_q;
            datain_d  = datain_q;
            phase_d   = phase_q;
            cur_idx_d = cur_idx_q;
        end

        // start trails the START state by one clock; done marks entry into DONE.
        start_d = (state_q == StStart) && !abort;
        done_d  = (state_d == StDone);
        busy_d  = (state_d != StIdle);
    end

    // State, configuration and output registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            trig_q      <= 1'b0;
            idx_q       <= '0;
            pass_q      <= '0;
            nw_q        <= '0;
            rep_q       <= '0;
            gap_lat_q   <= '0;
            to_lat_q    <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            datain_q    <= '0;
            phase_q     <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_idx_q   <= '0;
            data_mem_q  <= '{default: '0};
            phase_mem_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            trig_q      <= trig_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            nw_q        <= nw_d;
            rep_q       <= rep_d;
            gap_lat_q   <= gap_lat_d;
            to_lat_q    <= to_lat_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            datain_q    <= datain_d;
            phase_q     <= phase_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_idx_q   <= cur_idx_d;
            data_mem_q  <= data_mem_d;
            phase_mem_q <= phase_mem_d;
        end
    end

    assign datain      = datain_q;
    assign phase_delay = phase_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cur_idx     = cur_idx_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer with hand-computed expectations.
module tb_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trig = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic [7:0]  cfg_phase = '0;
    logic [2:0]  num_words = '0;
    logic [7:0]  repeat_cnt = '0;
    logic [15:0] gap_cycles = '0;
    logic [15:0] timeout_cycles = '0;
    logic        sysrun = 1'b0;
    logic [31:0] datain;
    logic [7:0]  phase_delay;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  cur_idx;

    int checks = 0;
    int fails = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int sc;
    int dc;
    logic [31:0] exp_data [3];

    burst_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .trig          (trig),
        .abort         (abort),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_phase     (cfg_phase),
        .num_words     (num_words),
        .repeat_cnt    (repeat_cnt),
        .gap_cycles    (gap_cycles),
        .timeout_cycles(timeout_cycles),
        .sysrun        (sysrun),
        .datain        (datain),
        .phase_delay   (phase_delay),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cur_idx       (cur_idx)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (start === 1'b1) start_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [31:0] d, input logic [7:0] p);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_phase = p;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Returns just after the edge that samples the rising trig.
    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (start !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, start, 1);
    endtask

    // Called with start high: sysrun rises next clock and stays for len clocks.
    task automatic run_burst(input int len);
        tick();
        sysrun = 1'b1;
        tick(len);
        sysrun = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst busy", busy, 0);
        check("rst start", start, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst datain", datain, 0);
        check("rst phase", phase_delay, 0);
        check("rst cur_idx", cur_idx, 0);
        rst = 1'b1;
        tick(2);

        // Single burst
        write_entry(2'd0, 32'hA5A5_0F0F, 8'd3);
        num_words = 3'd1; repeat_cnt = 8'd1; gap_cycles = 16'd4; timeout_cycles = 16'd0;
        sc = start_cnt; dc = done_cnt;
        trig = 1'b1;
        tick();
        check("single busy", busy, 1);
        check("single start early0", start, 0);
        trig = 1'b0;
        tick();
        check("single start early1", start, 0);
        check("single datain", datain, 32'hA5A5_0F0F);
        check("single phase", phase_delay, 3);
        tick();
        check("single start", start, 1);
        tick();
        check("single start width", start, 0);
        sysrun = 1'b1;
        tick(10);
        sysrun = 1'b0;
        tick();
        check("single gap busy", busy, 1);
        tick(4);
        check("single done early", done, 0);
        tick();
        check("single done", done, 1);
        tick();
        check("single done width", done, 0);
        check("single busy end", busy, 0);
        check("single start count", start_cnt - sc, 1);
        check("single done count", done_cnt - dc, 1);

        // Multi-word, multi-pass
        exp_data[0] = 32'h1111_1111; exp_data[1] = 32'h2222_2222; exp_data[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) write_entry(i[1:0], exp_data[i], 8'(i + 1));
        num_words = 3'd3; repeat_cnt = 8'd2; gap_cycles = 16'd2;
        sc = start_cnt; dc = done_cnt;
        pulse_trig();
        for (int i = 0; i < 6; i++) begin
            wait_start("multi start");
            check("multi cur_idx", cur_idx, i % 3);
            check("multi datain", datain, exp_data[i % 3]);
            check("multi phase", phase_delay, (i % 3) + 1);
            run_burst(3);
        end
        tick(15);
        check("multi start count", start_cnt - sc, 6);
        check("multi done count", done_cnt - dc, 1);
        check("multi busy end", busy, 0);

        // Timeout
        num_words = 3'd1; repeat_cnt = 8'd1; gap_cycles = 16'd0; timeout_cycles = 16'd5;
        dc = done_cnt;
        pulse_trig();
        tick(2);
        check("to start", start, 1);
        tick(5);
        check("to err early", err, 0);
        check("to busy early", busy, 1);
        tick();
        check("to err", err, 1);
        check("to idle", busy, 0);
        tick(3);
        check("to no done", done_cnt - dc, 0);
        timeout_cycles = 16'd0;
        pulse_trig();
        check("to err cleared", err, 0);
        wait_start("to retry start");
        run_burst(2);
        tick(10);

        // Invalid num_words
        sc = start_cnt;
        num_words = 3'd0;
        pulse_trig();
        tick(4);
        check("inv nw0 busy", busy, 0);
        num_words = 3'd5;
        pulse_trig();
        tick(4);
        check("inv nw5 busy", busy, 0);
        check("inv start count", start_cnt - sc, 0);

        // repeat_cnt = 0 runs once
        num_words = 3'd1; repeat_cnt = 8'd0; gap_cycles = 16'd0;
        sc = start_cnt; dc = done_cnt;
        pulse_trig();
        wait_start("rep0 start");
        run_burst(2);
        tick(10);
        check("rep0 start count", start_cnt - sc, 1);
        check("rep0 done count", done_cnt - dc, 1);

        // Abort during WAIT_END of burst 2 of 4
        write_entry(2'd3, 32'h4444_4444, 8'd4);
        num_words = 3'd4; repeat_cnt = 8'd1; gap_cycles = 16'd1;
        sc = start_cnt; dc = done_cnt;
        pulse_trig();
        wait_start("abort b0 start");
        run_burst(2);
        wait_start("abort b1 start");
        check("abort b1 idx", cur_idx, 1);
        tick();
        sysrun = 1'b1;
        tick(2);
        abort = 1'b1;
        tick();
        check("abort idle", busy, 0);
        abort = 1'b0;
        sysrun = 1'b0;
        tick(20);
        check("abort start count", start_cnt - sc, 2);
        check("abort no done", done_cnt - dc, 0);
        check("abort err", err, 0);

        // gap_cycles = 0 and table write to entry 1 during burst 0
        num_words = 3'd2; repeat_cnt = 8'd1; gap_cycles = 16'd0;
        pulse_trig();
        wait_start("gap0 b0 start");
        write_entry(2'd1, 32'hDEAD_BEEF, 8'd9);
        sysrun = 1'b1;
        tick(3);
        sysrun = 1'b0;
        tick(3);
        check("gap0 start early", start, 0);
        tick();
        check("gap0 start", start, 1);
        check("wr datain", datain, 32'hDEAD_BEEF);
        check("wr phase", phase_delay, 9);
        check("wr cur_idx", cur_idx, 1);
        run_burst(2);
        tick(10);

        // Async reset mid-GAP
        write_entry(2'd0, 32'h5555_AAAA, 8'd7);
        num_words = 3'd1; gap_cycles = 16'd10;
        pulse_trig();
        wait_start("arst start");
        run_burst(2);
        tick(3);
        check("arst pre busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst datain", datain, 0);
        check("arst phase", phase_delay, 0);
        check("arst start", start, 0);
        check("arst done", done, 0);
        check("arst err", err, 0);
        rst = 1'b1;
        tick(2);
        pulse_trig();
        tick();
        check("arst table clr data", datain, 0);
        check("arst table clr phase", phase_delay, 0);
        wait_start("arst restart");
        run_burst(2);
        tick(15);
        check("arst final busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
